// File: rtl/input_port_cluster_fifo.sv
// Per-channel FWFT input FIFOs demuxed from one leaf stream, with round-robin freespace credit return.
// Define INPUT_PORT_CLUSTER_OVERFLOW_FLAG_EN to enable sticky per-channel drop flags.
module input_port_cluster_fifo #(
   parameter int NUM_LEAF_BITS         = 6,
   parameter int NUM_PORT_BITS         = 4,
   parameter int PAYLOAD_BITS          = 64,
   parameter int NUM_IN_PORTS          = 7,
   parameter int PORT_BASE             = 2,
   parameter int FIFO_DEPTH_BITS       = 5,
   parameter int FREESPACE_UPDATE_SIZE = 16,
   localparam int PACKET_BITS = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + PAYLOAD_BITS
) (
   input  logic                                               clk,
   input  logic                                               reset,
   input  logic [PACKET_BITS-1:0]                             stream_in,
   input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] in_control_reg,
   output logic [PACKET_BITS-1:0]                             credit_out,
   output logic                                               credit_vld,
   input  logic                                               credit_rdy,
   output logic [PAYLOAD_BITS*NUM_IN_PORTS-1:0]               dout2user,
   output logic [NUM_IN_PORTS-1:0]                            vld2user,
   input  logic [NUM_IN_PORTS-1:0]                            ack_user2b_in,
   output logic [NUM_IN_PORTS-1:0]                            overflow,
   input  logic                                               overflow_clr
);

   localparam int DEPTH     = 2 ** FIFO_DEPTH_BITS;
   localparam int PTR_W     = FIFO_DEPTH_BITS + 1;
   localparam int CTRL_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
   localparam int PCNT_BITS = $clog2(FREESPACE_UPDATE_SIZE + 1);
   localparam int IDX_BITS  = (NUM_IN_PORTS > 1) ? $clog2(NUM_IN_PORTS) : 1;

   typedef enum logic {ST_IDLE, ST_SEND} state_e;

   logic                       in_vld;
   logic [NUM_PORT_BITS-1:0]   in_port;
   logic [PAYLOAD_BITS-1:0]    in_payload;
   logic                       unused_bits;

   logic [PAYLOAD_BITS-1:0]    mem_q     [NUM_IN_PORTS][DEPTH];
   logic [PTR_W-1:0]           wr_ptr_q  [NUM_IN_PORTS];
   logic [PTR_W-1:0]           rd_ptr_q  [NUM_IN_PORTS];
   logic [PCNT_BITS-1:0]       pop_cnt_q [NUM_IN_PORTS];
   logic [PTR_W-1:0]           owed_q    [NUM_IN_PORTS];
   logic [PAYLOAD_BITS-1:0]    last_q    [NUM_IN_PORTS];

   logic [NUM_IN_PORTS-1:0]    hit, full, empty, push, pop, credit_inc, grant;

   state_e                     state_q, state_d;
   logic [IDX_BITS-1:0]        rr_q, rr_d;
   logic [IDX_BITS-1:0]        cand, sel;
   logic                       found;
   logic [PACKET_BITS-1:0]     credit_out_q, credit_out_d;
   logic                       credit_vld_q, credit_vld_d;

   assign in_vld     = stream_in[PACKET_BITS-1];
   assign in_port    = stream_in[PAYLOAD_BITS +: NUM_PORT_BITS];
   assign in_payload = stream_in[PAYLOAD_BITS-1:0];

   always_comb begin
      hit        = '0;
      full       = '0;
      empty      = '0;
      push       = '0;
      pop        = '0;
      credit_inc = '0;
      vld2user   = '0;
      dout2user  = '0;
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
         hit[i]   = in_vld && (int'(in_port) == PORT_BASE + int'(i));
         empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
         full[i]  = (wr_ptr_q[i][FIFO_DEPTH_BITS-1:0] == rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]) &&
                    (wr_ptr_q[i][FIFO_DEPTH_BITS] != rd_ptr_q[i][FIFO_DEPTH_BITS]);
         push[i]  = hit[i] && !full[i];
         pop[i]   = ack_user2b_in[i] && !empty[i];
         credit_inc[i] = pop[i] && (pop_cnt_q[i] == PCNT_BITS'(FREESPACE_UPDATE_SIZE - 1));
         vld2user[i]   = !empty[i];
         // An empty FIFO shows the last popped word rather than stale storage.
         dout2user[i*PAYLOAD_BITS +: PAYLOAD_BITS] =
            empty[i] ? last_q[i] : mem_q[i][rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i][FIFO_DEPTH_BITS-1:0]] <= in_payload;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
            wr_ptr_q[i]  <= '0;
            rd_ptr_q[i]  <= '0;
            pop_cnt_q[i] <= '0;
            owed_q[i]    <= '0;
            last_q[i]    <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
            if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
            if (pop[i]) begin
               rd_ptr_q[i]  <= rd_ptr_q[i] + PTR_W'(1);
               last_q[i]    <= mem_q[i][rd_ptr_q[i][FIFO_DEPTH_BITS-1:0]];
               pop_cnt_q[i] <= credit_inc[i] ? '0 : pop_cnt_q[i] + PCNT_BITS'(1);
            end
            case ({credit_inc[i], grant[i]})
               2'b10:   owed_q[i] <= owed_q[i] + PTR_W'(1);
               2'b01:   owed_q[i] <= owed_q[i] - PTR_W'(1);
               default: owed_q[i] <= owed_q[i];
            endcase
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_d         = rr_q;
      credit_out_d = credit_out_q;
      credit_vld_d = credit_vld_q;
      grant        = '0;
      found        = 1'b0;
      sel          = '0;
      cand         = '0;
      // First channel with owed credit, scanning upward from the round-robin pointer.
      for (int unsigned k = 0; k < NUM_IN_PORTS; k++) begin
         cand = IDX_BITS'((32'(rr_q) + k) % NUM_IN_PORTS);
         if (!found && owed_q[cand] != '0) begin
            found = 1'b1;
            sel   = cand;
         end
      end
      case (state_q)
         ST_IDLE: begin
            if (found) begin
               grant[sel]   = 1'b1;
               credit_out_d = {1'b1, in_control_reg[int'(sel)*CTRL_BITS +: CTRL_BITS],
                               PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE)};
               credit_vld_d = 1'b1;
               rr_d         = (int'(sel) == NUM_IN_PORTS - 1) ? '0 : sel + IDX_BITS'(1);
               state_d      = ST_SEND;
            end
         end
         ST_SEND: begin
            if (credit_rdy) begin
               credit_vld_d = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         rr_q         <= '0;
         credit_out_q <= '0;
         credit_vld_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_q         <= rr_d;
         credit_out_q <= credit_out_d;
         credit_vld_q <= credit_vld_d;
      end
   end

   assign credit_out = credit_out_q;
   assign credit_vld = credit_vld_q;

`ifdef INPUT_PORT_CLUSTER_OVERFLOW_FLAG_EN
   logic [NUM_IN_PORTS-1:0] ovf_q;

   // A drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_IN_PORTS; i++) begin
            if (hit[i] && full[i])  ovf_q[i] <= 1'b1;
            else if (overflow_clr)  ovf_q[i] <= 1'b0;
         end
      end
   end

   assign overflow    = ovf_q;
   assign unused_bits = ^stream_in[PAYLOAD_BITS+NUM_PORT_BITS +: NUM_LEAF_BITS];
`else
   assign overflow    = '0;
   assign unused_bits = ^{stream_in[PAYLOAD_BITS+NUM_PORT_BITS +: NUM_LEAF_BITS], overflow_clr};
`endif

endmodule

// File: tb/tb_input_port_cluster_fifo.sv
// Directed plus randomized bench for input_port_cluster_fifo against a queue-based reference model.
module tb_input_port_cluster_fifo;

   localparam int LB = 6, PB = 4, DB = 64, N = 7, BASE = 2, FDB = 5, FU = 16;
   localparam int PKT = 1 + LB + PB + DB;
   localparam int DEPTH = 32;
   localparam int CB = LB + PB;
`ifdef INPUT_PORT_CLUSTER_OVERFLOW_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [PKT-1:0]    stream_in;
   logic [CB*N-1:0]   in_control_reg;
   logic [PKT-1:0]    credit_out;
   logic              credit_vld;
   logic              credit_rdy;
   logic [DB*N-1:0]   dout2user;
   logic [N-1:0]      vld2user;
   logic [N-1:0]      ack_user2b_in;
   logic [N-1:0]      overflow;
   logic              overflow_clr;

   always #5 clk = ~clk;

   input_port_cluster_fifo #(
      .NUM_LEAF_BITS(LB), .NUM_PORT_BITS(PB), .PAYLOAD_BITS(DB), .NUM_IN_PORTS(N),
      .PORT_BASE(BASE), .FIFO_DEPTH_BITS(FDB), .FREESPACE_UPDATE_SIZE(FU)
   ) dut (
      .clk(clk), .reset(reset), .stream_in(stream_in), .in_control_reg(in_control_reg),
      .credit_out(credit_out), .credit_vld(credit_vld), .credit_rdy(credit_rdy),
      .dout2user(dout2user), .vld2user(vld2user), .ack_user2b_in(ack_user2b_in),
      .overflow(overflow), .overflow_clr(overflow_clr)
   );

   // Reference model: one queue per channel, total pop counts, owed credits, a busy credit slot.
   logic [DB-1:0]  mq [N][$];
   logic [DB-1:0]  m_last [N];
   int             m_pops [N];
   int             m_owed [N];
   bit             m_ovf  [N];
   int             m_last_gnt;
   bit             m_vld;
   logic [PKT-1:0] m_out;

   int n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         mq[i].delete();
         m_last[i] = '0; m_pops[i] = 0; m_owed[i] = 0; m_ovf[i] = 1'b0;
      end
      m_last_gnt = N - 1;
      m_vld = 1'b0;
      m_out = '0;
   endfunction

   function automatic void model_edge(input logic [PKT-1:0] s, input logic [N-1:0] a,
                                      input logic rdy, input logic clr);
      bit got;
      int g;
      got = 1'b0; g = 0;
      if (!m_vld) begin
         for (int k = 1; k <= N; k++) begin
            if (!got && m_owed[(m_last_gnt + k) % N] > 0) begin
               got = 1'b1; g = (m_last_gnt + k) % N;
            end
         end
         if (got) begin
            m_owed[g]--;
            m_last_gnt = g;
            m_vld = 1'b1;
            m_out = {1'b1, in_control_reg[g*CB +: CB], 64'(FU)};
         end
      end else if (rdy) begin
         m_vld = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         bit is_full, hit;
         is_full = (mq[i].size() == DEPTH);
         hit = s[PKT-1] && (int'(s[DB +: PB]) == BASE + i);
         if (a[i] && mq[i].size() > 0) begin
            m_last[i] = mq[i].pop_front();
            m_pops[i]++;
            if (m_pops[i] % FU == 0) m_owed[i]++;
         end
         if (hit && !is_full) mq[i].push_back(s[DB-1:0]);
         if (OVF_EN) begin
            if (hit && is_full) m_ovf[i] = 1'b1;
            else if (clr)       m_ovf[i] = 1'b0;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic [N-1:0] ev, eo;
      for (int i = 0; i < N; i++) begin
         ev[i] = (mq[i].size() != 0);
         eo[i] = m_ovf[i];
         chk($sformatf("dout%0d", i), dout2user[i*DB +: DB],
             (mq[i].size() != 0) ? mq[i][0] : m_last[i]);
      end
      chk("vld2user", vld2user, ev);
      chk("overflow", overflow, eo);
      chk("credit_vld", credit_vld, m_vld);
      chk("credit_out", credit_out, m_out);
   endtask

   task automatic step(input logic [PKT-1:0] s, input logic [N-1:0] a, input logic rdy, input logic clr);
      stream_in = s; ack_user2b_in = a; credit_rdy = rdy; overflow_clr = clr;
      model_edge(s, a, rdy, clr);
      @(posedge clk); #1;
      cyc++;
      check_outputs();
   endtask

   function automatic logic [PKT-1:0] pkt(input int port, input logic [DB-1:0] pl);
      return {1'b1, 6'h2A, 4'(port), pl};
   endfunction

   initial begin
      int cnt;
      int rise_cyc[$];
      logic [PB-1:0] rise_port[$];
      logic prev;
      logic [PKT-1:0] rs;
      logic [N-1:0] ra;

      reset = 1'b1; stream_in = '0; ack_user2b_in = '0; credit_rdy = 1'b0; overflow_clr = 1'b0;
      for (int i = 0; i < N; i++) in_control_reg[i*CB +: CB] = {6'(10 + i), 4'(i)};
      model_reset();
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      check_outputs();
      chk("rst_vld2user", vld2user, '0);
      chk("rst_credit_vld", credit_vld, 1'b0);

      // Accept and FWFT on channel 1 (port 3)
      step(pkt(3, 64'hA5), '0, 1'b0, 1'b0);
      chk("fwft_vld", vld2user, 7'b0000010);
      chk("fwft_dout1", dout2user[1*DB +: DB], 64'hA5);
      step('0, 7'b0000010, 1'b0, 1'b0);
      chk("fwft_popped", vld2user, '0);
      chk("fwft_hold", dout2user[1*DB +: DB], 64'hA5);

      // Overflow on channel 0: 33 writes, 33rd dropped
      for (int k = 0; k < 33; k++) step(pkt(BASE, 64'(k)), '0, 1'b0, 1'b0);
      chk("ovf_set", overflow[0], OVF_EN);
      step('0, '0, 1'b0, 1'b1);
      chk("ovf_clr", overflow[0], 1'b0);
      cnt = 0;
      while (vld2user[0] && cnt < 40) begin step('0, 7'b0000001, 1'b1, 1'b0); cnt++; end
      chk("ovf_stored", 32'(cnt), 32'd32);
      chk("ovf_last", dout2user[0 +: DB], 64'd31);
      repeat (8) step('0, '0, 1'b1, 1'b0);

      // Credit issue from channel 2 with {leaf 5, port 9}
      in_control_reg[2*CB +: CB] = {6'd5, 4'd9};
      for (int k = 0; k < 16; k++) step(pkt(BASE + 2, 64'(100 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step('0, 7'b0000100, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      chk("cr_vld", credit_vld, 1'b1);
      chk("cr_out", credit_out, {1'b1, 6'd5, 4'd9, 64'd16});
      for (int k = 0; k < 4; k++) begin
         step('0, '0, 1'b0, 1'b0);
         chk("cr_hold_vld", credit_vld, 1'b1);
         chk("cr_hold_out", credit_out, {1'b1, 6'd5, 4'd9, 64'd16});
      end
      step('0, '0, 1'b1, 1'b0);
      chk("cr_release", credit_vld, 1'b0);

      // Push and pop together on a full FIFO (channel 1)
      for (int k = 0; k < 32; k++) step(pkt(BASE + 1, 64'(200 + k)), '0, 1'b1, 1'b0);
      step(pkt(BASE + 1, 64'hDEAD), 7'b0000010, 1'b1, 1'b0);
      cnt = 0;
      while (vld2user[1] && cnt < 40) begin step('0, 7'b0000010, 1'b1, 1'b0); cnt++; end
      chk("full_pushpop_occ", 32'(cnt), 32'd31);
      repeat (8) step('0, '0, 1'b1, 1'b0);

      // Round-robin among channels 0, 3, 6 with an extra credit on channel 0
      for (int i = 0; i < N; i++) in_control_reg[i*CB +: CB] = {6'(10 + i), 4'(i)};
      for (int k = 0; k < 32; k++) step(pkt(BASE + 0, 64'(300 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step(pkt(BASE + 3, 64'(400 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step(pkt(BASE + 6, 64'(500 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step('0, 7'b0000001, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      chk("rr_first", {credit_vld, credit_out[DB +: PB]}, {1'b1, 4'd0});
      for (int k = 0; k < 16; k++) step('0, 7'b1001001, 1'b0, 1'b0);
      repeat (2) step('0, '0, 1'b0, 1'b0);
      prev = credit_vld;
      for (int k = 0; k < 20; k++) begin
         step('0, '0, 1'b1, 1'b0);
         if (credit_vld && !prev) begin
            rise_port.push_back(credit_out[DB +: PB]);
            rise_cyc.push_back(cyc);
         end
         prev = credit_vld;
      end
      chk("rr_count", 32'(rise_port.size()), 32'd3);
      if (rise_port.size() >= 3) begin
         chk("rr_order0", rise_port[0], 4'd3);
         chk("rr_order1", rise_port[1], 4'd6);
         chk("rr_order2", rise_port[2], 4'd0);
         chk("rr_gap0", 32'(rise_cyc[1] - rise_cyc[0]), 32'd2);
         chk("rr_gap1", 32'(rise_cyc[2] - rise_cyc[1]), 32'd2);
      end

      // Mid-operation reset with credit pending and data buffered
      for (int k = 0; k < 3; k++) step(pkt(BASE + 4, 64'(600 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step(pkt(BASE + 5, 64'(700 + k)), '0, 1'b0, 1'b0);
      for (int k = 0; k < 16; k++) step('0, 7'b0100000, 1'b0, 1'b0);
      step('0, '0, 1'b0, 1'b0);
      chk("mr_pre_vld", credit_vld, 1'b1);
      #3 reset = 1'b1;
      #1;
      chk("mr_vld2user", vld2user, '0);
      chk("mr_credit_vld", credit_vld, 1'b0);
      chk("mr_credit_out", credit_out, '0);
      chk("mr_overflow", overflow, '0);
      chk("mr_dout4", dout2user[4*DB +: DB], '0);
      model_reset();
      @(posedge clk);
      #3 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step('0, '0, 1'b0, 1'b0);
         chk("mr_no_credit", credit_vld, 1'b0);
      end

      // Randomized traffic
      for (int i = 0; i < N; i++) in_control_reg[i*CB +: CB] = CB'($urandom);
      for (int k = 0; k < 2000; k++) begin
         rs = {1'($urandom_range(0, 3) != 0), 6'($urandom), 4'($urandom_range(0, 15)), $urandom, $urandom};
         for (int i = 0; i < N; i++) ra[i] = (k < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
         step(rs, ra, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
